// File: rtl/snake_pkg.sv
// Shared board geometry, cell colour codes and writer state encoding.
// Cell code bits [2:0] map to R,G,B on the VGA pixel path.
package snake_pkg;

  localparam int COLS  = 32;
  localparam int ROWS  = 24;
  localparam int CELLS = COLS * ROWS;

  localparam logic [7:0] CELL_BLACK   = 8'd0;
  localparam logic [7:0] CELL_BLUE    = 8'd1;
  localparam logic [7:0] CELL_GREEN   = 8'd2;
  localparam logic [7:0] CELL_CYAN    = 8'd3;
  localparam logic [7:0] CELL_RED     = 8'd4;
  localparam logic [7:0] CELL_MAGENTA = 8'd5;
  localparam logic [7:0] CELL_YELLOW  = 8'd6;
  localparam logic [7:0] CELL_WHITE   = 8'd7;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    CLEAR
  } wr_state_t;

endpackage

// File: rtl/tile_req_fifo.sv
// Synchronous request queue with flush; head word is always visible.
// Pointers wrap modulo DEPTH so non-power-of-two depths work.
module tile_req_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  function automatic logic [AW-1:0] bump(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= bump(wptr);
      if (do_pop)  rptr <= bump(rptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/board_writer.sv
// Serialises game-logic cell writes and full-board fills onto the
// shared board RAM write port, yielding whenever the VGA reader owns it.
module board_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int COLS       = snake_pkg::COLS,
  parameter int ROWS       = snake_pkg::ROWS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [4:0] req_x,
  input  logic [4:0] req_y,
  input  logic [7:0] req_data,
  input  logic       clear_start,
  input  logic [7:0] clear_data,
  input  logic       vga_re,
  output logic       mem_we,
  output logic [9:0] mem_waddr,
  output logic [7:0] mem_wdata,
  output logic       busy,
  output logic       done,
  output logic       err_oob
);
  import snake_pkg::*;

  localparam int         CW     = $clog2(FIFO_DEPTH + 1);
  localparam logic [4:0] X_LAST = 5'(COLS - 1);
  localparam logic [4:0] Y_LAST = 5'(ROWS - 1);
  localparam logic [5:0] Y_LIM  = 6'(ROWS);

  wr_state_t     state, state_d;
  logic          full, empty;
  logic [CW-1:0] count;
  logic [17:0]   head;
  logic          accept, oob, push, pop, flush;
  logic [4:0]    sx, sy, sx_d, sy_d;
  logic [7:0]    fill, fill_d;
  logic          we_d, done_d, oob_d;
  logic [9:0]    waddr_d;
  logic [7:0]    wdata_d;

  assign req_ready = reset && !full && state != CLEAR
                     && !clear_start;
  assign accept    = req_valid && req_ready;
  assign oob       = {1'b0, req_y} >= Y_LIM;
  assign push      = accept && !oob;
  assign busy      = state == CLEAR || !empty;

  tile_req_fifo #(
    .WIDTH (18),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .wdata ({req_y, req_x, req_data}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    state_d = state;
    pop     = 1'b0;
    flush   = 1'b0;
    sx_d    = sx;
    sy_d    = sy;
    fill_d  = fill;
    we_d    = 1'b0;
    waddr_d = mem_waddr;
    wdata_d = mem_wdata;
    done_d  = 1'b0;
    oob_d   = accept && oob;
    unique case (state)
      IDLE, DRAIN: begin
        if (clear_start) begin
          flush   = 1'b1;
          fill_d  = clear_data;
          sx_d    = '0;
          sy_d    = '0;
          state_d = CLEAR;
        end else begin
          pop = !empty && !vga_re;
          if (pop) begin
            we_d    = 1'b1;
            waddr_d = head[17:8];
            wdata_d = head[7:0];
          end
          state_d = (push || count > CW'(pop)) ? DRAIN : IDLE;
        end
      end
      CLEAR: begin
        if (!vga_re) begin
          we_d    = 1'b1;
          waddr_d = {sy, sx};
          wdata_d = fill;
          if (sx == X_LAST && sy == Y_LAST) begin
            done_d  = 1'b1;
            sx_d    = '0;
            sy_d    = '0;
            state_d = IDLE;
          end else if (sx == X_LAST) begin
            sx_d = '0;
            sy_d = sy + 1'b1;
          end else begin
            sx_d = sx + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sx        <= '0;
      sy        <= '0;
      fill      <= '0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      err_oob   <= 1'b0;
    end else begin
      state     <= state_d;
      sx        <= sx_d;
      sy        <= sy_d;
      fill      <= fill_d;
      mem_we    <= we_d;
      mem_waddr <= waddr_d;
      mem_wdata <= wdata_d;
      done      <= done_d;
      err_oob   <= oob_d;
    end
  end

endmodule

// File: tb/tb_board_writer.sv
// Randomised scoreboard bench for board_writer: a queue-level model
// predicts writes, a monitor pops and compares them as they appear.
module tb_board_writer;
  import snake_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [4:0] req_x = '0;
  logic [4:0] req_y = '0;
  logic [7:0] req_data = '0;
  logic       clear_start = 1'b0;
  logic [7:0] clear_data = '0;
  logic       vga_re = 1'b0;
  logic       mem_we;
  logic [9:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic       busy;
  logic       done;
  logic       err_oob;

  always #5 clk = ~clk;

  board_writer #(
    .FIFO_DEPTH (DEPTH),
    .COLS       (COLS),
    .ROWS       (ROWS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_data    (req_data),
    .clear_start (clear_start),
    .clear_data  (clear_data),
    .vga_re      (vga_re),
    .mem_we      (mem_we),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .busy        (busy),
    .done        (done),
    .err_oob     (err_oob)
  );

  typedef struct {
    int addr;
    int data;
    bit last;
  } wr_t;

  typedef struct {
    bit we;
    bit oob;
    bit busy;
  } cyc_t;

  wr_t  exp_q[$];
  wr_t  model_q[$];
  cyc_t cyc_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   mon_on = 0;
  bit   clearing = 0;
  int   sweep = 0;
  int   fill = 0;
  int   done_seen = 0;
  int   done_exp = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at negedge and advance the model
  task automatic step(input bit v, input int x, input int y,
                      input int d, input bit cs, input int cd,
                      input bit re);
    bit   rdy, acc, oob, we;
    wr_t  w;
    cyc_t c;
    @(negedge clk);
    req_valid   = v;
    req_x       = 5'(x);
    req_y       = 5'(y);
    req_data    = 8'(d);
    clear_start = cs;
    clear_data  = 8'(cd);
    vga_re      = re;
    rdy = !clearing && !cs && model_q.size() < DEPTH;
    acc = v && rdy;
    oob = acc && y >= ROWS;
    we  = 0;
    if (clearing) begin
      if (!re) begin
        w.addr = (sweep / COLS) * 32 + sweep % COLS;
        w.data = fill;
        w.last = sweep == CELLS - 1;
        exp_q.push_back(w);
        we = 1;
        sweep++;
        if (w.last) begin
          clearing = 0;
          done_exp++;
        end
      end
    end else if (cs) begin
      model_q.delete();
      clearing = 1;
      sweep    = 0;
      fill     = cd;
    end else begin
      if (model_q.size() > 0 && !re) begin
        exp_q.push_back(model_q.pop_front());
        we = 1;
      end
      if (acc && !oob) begin
        w.addr = y * 32 + x;
        w.data = d;
        w.last = 0;
        model_q.push_back(w);
      end
    end
    c.we   = we;
    c.oob  = oob;
    c.busy = clearing || model_q.size() > 0;
    cyc_q.push_back(c);
    #1 chk("req_ready", req_ready, rdy);
  endtask

  task automatic idle(input int n, input bit re);
    repeat (n) step(0, 0, 0, 0, 0, 0, re);
  endtask

  task automatic do_reset();
    mon_on = 0;
    cyc_q.delete();
    exp_q.delete();
    model_q.delete();
    clearing    = 0;
    sweep       = 0;
    req_valid   = 0;
    clear_start = 0;
    vga_re      = 0;
    reset       = 0;
    #1;
    chk("rst_mem_we", mem_we, 0);
    chk("rst_waddr", mem_waddr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_done", done, 0);
    chk("rst_err_oob", err_oob, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    chk("rst_hold_we", mem_we, 0);
    reset = 1;
    #1 chk("ready_after_rst", req_ready, 1);
    mon_on = 1;
  endtask

  initial begin
    cyc_t c;
    wr_t  w;
    forever begin
      @(posedge clk);
      #2;
      if (mon_on && cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        chk("mem_we", mem_we, c.we);
        chk("err_oob", err_oob, c.oob);
        chk("busy", busy, c.busy);
        if (mem_we === 1'b1) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: addr %0d data %0h",
                     mem_waddr, mem_wdata);
          end else begin
            w = exp_q.pop_front();
            chk("waddr", mem_waddr, w.addr);
            chk("wdata", mem_wdata, w.data);
            chk("done", done, w.last);
          end
        end else begin
          chk("done_idle", done, 0);
        end
        if (done === 1'b1) done_seen++;
      end
    end
  end

  initial begin
    #3;
    do_reset();

    // single write: x=3,y=2 lands at 67 two cycles later
    step(1, 3, 2, 8'h04, 0, 0, 0);
    idle(4, 0);

    // five pushes while VGA holds the port; fifth is refused
    for (int i = 0; i < 5; i++)
      step(1, i + 1, i, 16 + i, 0, 0, 1);
    idle(2, 1);
    idle(6, 0);

    // out-of-range row, alone and behind queued work
    step(1, 5, 24, 8'h07, 0, 0, 0);
    idle(3, 0);
    step(1, 9, 1, 8'h11, 0, 0, 1);
    step(1, 10, 1, 8'h12, 0, 0, 1);
    step(1, 6, 31, 8'h13, 0, 0, 1);
    idle(5, 0);

    // full clear with VGA toggling every cycle
    step(0, 0, 0, 0, 1, 8'h02, 0);
    for (int i = 0; i < 1540; i++)
      step(0, 0, 0, 0, 0, 0, (i % 2) == 0);
    idle(3, 0);

    // clear discards queued writes; a second clear is ignored
    for (int i = 0; i < 3; i++)
      step(1, 20 + i, 3, 8'h30 + i, 0, 0, 1);
    step(0, 0, 0, 0, 1, 8'h05, 1);
    idle(100, 0);
    step(1, 1, 1, 8'h77, 1, 8'h3c, 0);
    idle(700, 0);

    // random traffic with occasional clears
    for (int i = 0; i < 2000; i++)
      step($urandom % 2, $urandom % 32, $urandom % 28,
           $urandom % 256, ($urandom % 400) == 0,
           $urandom % 256, ($urandom % 3) == 0);
    idle(1200, 0);

    // reset in the middle of a sweep
    step(0, 0, 0, 0, 1, 8'h06, 0);
    idle(400, 0);
    do_reset();
    idle(4, 0);
    step(1, 31, 23, 8'h01, 0, 0, 0);
    idle(4, 0);

    chk("exp_q_drained", exp_q.size(), 0);
    chk("done_pulses", done_seen, done_exp);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
